// File: rtl/sha256_pkg.sv
// sha256_pkg -- shared types, constants and bit-mixing functions for the
// SHA-256 block engine.
//   word_t  : one 32-bit SHA-256 word
//   hash_t  : 8 words, index 0 = H0/a (bits [255:224]) ... 7 = H7/h
//   block_t : 16 words, index 0 = W0 (bits [511:480]) ... 15 = W15
//   state_t : engine control states
//   K, IV   : round constants and standard initial hash value
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [0:7]  hash_t;
  typedef word_t [0:15] block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_t;

  localparam hash_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotations are written as fixed concatenations so no shifter is implied.
  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round -- one combinational SHA-256 compression round.
// Ports:
//   state_in  : working variables a..h (index 0 = a)
//   k         : round constant K[t]
//   w         : schedule word W[t]
//   state_out : working variables after the round
module sha256_round
  import sha256_pkg::*;
(
  input  hash_t state_in,
  input  word_t k,
  input  word_t w,
  output hash_t state_out
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = state_in[7] + big_sigma1(state_in[4])
       + ch(state_in[4], state_in[5], state_in[6]) + k + w;
    t2 = big_sigma0(state_in[0]) + maj(state_in[0], state_in[1], state_in[2]);
    state_out = {t1 + t2, state_in[0], state_in[1], state_in[2],
                 state_in[3] + t1, state_in[4], state_in[5], state_in[6]};
  end

endmodule

// File: rtl/sha256_block_engine.sv
// sha256_block_engine -- single-block SHA-256 compression, one round/clock.
// A start latches a 512-bit block and 256-bit chaining value, runs 64 rounds,
// adds the working variables back onto the chaining value and reports done.
// Ports:
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   begin_sha  : start request, sampled only when not busy (IDLE/DONE)
//   abort      : (only with SHA256_ABORT_EN defined) cancel a running job
//   block_in   : message block, [511:480] = W0 ... [31:0] = W15
//   hash_in    : chaining value, [255:224] = H0 ... [31:0] = H7
//   busy       : high from the accepting edge until the completing edge
//   complete   : result valid on hash_out
//   hash_out   : final hash, held until the next job completes
// Parameter COMPLETE_PULSE: 1 = complete is a one-cycle pulse,
//   0 = complete holds until the next accepted start or reset.
// Optional macro SHA256_ABORT_EN adds the abort input.
module sha256_block_engine
  import sha256_pkg::*;
#(
  parameter bit COMPLETE_PULSE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         begin_sha,
`ifdef SHA256_ABORT_EN
  input  logic         abort,
`endif
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic         busy,
  output logic         complete,
  output logic [255:0] hash_out
);

  state_t     state;
  logic [5:0] t;
  block_t     w;        // w[0] is W[t]; w[j] is W[t+j]
  hash_t      h_reg;    // chaining value for the final addition
  hash_t      work;     // working variables a..h
  hash_t      work_next;
  hash_t      hash_sum;
  word_t      w_new;
  logic       start;
  logic       abort_hit;

  assign start = ((state == ST_IDLE) || (state == ST_DONE)) && begin_sha;

`ifdef SHA256_ABORT_EN
  // busy is high exactly in ROUND and FINAL, the only states abort acts in.
  assign abort_hit = abort && busy;
`else
  assign abort_hit = 1'b0;
`endif

  sha256_round u_round (
    .state_in  (work),
    .k         (K[t]),
    .w         (w[0]),
    .state_out (work_next)
  );

  // NOTE: every variable gets a value on every path through always_comb,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    for (int i = 0; i < 8; i++) begin
      hash_sum[i] = h_reg[i] + work[i];
    end
  end

  // NOTE: the datapath registers carry no reset; each job loads them on its
  // accepting edge, and nothing reads them before that.
  always_ff @(posedge clk) begin
    if (start) begin
      w     <= block_in;
      h_reg <= hash_in;
      work  <= hash_in;
    end else if (state == ST_ROUND) begin
      work <= work_next;
      w    <= {w[1:15], w_new};
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      complete <= 1'b0;
      hash_out <= '0;
      t        <= '0;
    end else if (abort_hit) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      t     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (begin_sha) begin
            state <= ST_ROUND;
            busy  <= 1'b1;
            t     <= '0;
          end
        end
        ST_ROUND: begin
          t <= t + 6'd1;    // wraps to 0 after round 63
          if (t == 6'd63) state <= ST_FINAL;
        end
        ST_FINAL: begin
          hash_out <= hash_sum;
          complete <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          if (begin_sha) begin
            state    <= ST_ROUND;
            busy     <= 1'b1;
            complete <= 1'b0;
            t        <= '0;
          end else if (COMPLETE_PULSE) begin
            state    <= ST_IDLE;
            complete <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_engine.sv
// Testbench for sha256_block_engine: known-answer vectors plus start-ignore,
// reset-abort, hold-mode, back-to-back and (with SHA256_ABORT_EN) abort cases.
module tb_sha256_block_engine;

  localparam logic [255:0] IV_C =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [255:0] ABC_HASH =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] EMPTY_BLK  = {32'h80000000, {15{32'h0}}};
  localparam logic [255:0] EMPTY_HASH =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] TWO_BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [255:0] TWO_MID =
    256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [511:0] TWO_BLK2 = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] TWO_HASH =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct {
    logic [511:0] blk;
    logic [255:0] hin;
    logic [255:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         begin_p = 1'b0;
  logic         begin_h = 1'b0;
  logic         abort = 1'b0;
  logic [511:0] block_in = '0;
  logic [255:0] hash_in = '0;
  logic         busy_p, complete_p, busy_h, complete_h;
  logic [255:0] hash_p, hash_h;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sha256_block_engine #(.COMPLETE_PULSE(1'b1)) dut_p (
    .clk       (clk),
    .rst       (rst),
    .begin_sha (begin_p),
`ifdef SHA256_ABORT_EN
    .abort     (abort),
`endif
    .block_in  (block_in),
    .hash_in   (hash_in),
    .busy      (busy_p),
    .complete  (complete_p),
    .hash_out  (hash_p)
  );

  sha256_block_engine #(.COMPLETE_PULSE(1'b0)) dut_h (
    .clk       (clk),
    .rst       (rst),
    .begin_sha (begin_h),
`ifdef SHA256_ABORT_EN
    .abort     (1'b0),
`endif
    .block_in  (block_in),
    .hash_in   (hash_in),
    .busy      (busy_h),
    .complete  (complete_h),
    .hash_out  (hash_h)
  );

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a job and pulse begin for the sampling edge N; returns #1 after N.
  task automatic start_job(input bit sel, input logic [511:0] b,
                           input logic [255:0] h);
    @(negedge clk);
    block_in = b;
    hash_in  = h;
    if (sel) begin_h = 1'b1; else begin_p = 1'b1;
    @(posedge clk); #1;
    begin_p = 1'b0;
    begin_h = 1'b0;
  endtask

  // Advance edge by edge until complete; lat = edges since acceptance.
  task automatic wait_done(input bit sel, input int lat0, output int lat);
    lat = lat0;
    while (!(sel ? complete_h : complete_p) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic count_completes(input bit sel, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (sel ? complete_h : complete_p) cnt++;
    end
  endtask

  initial begin
    vec_t vecs [4];
    int   lat;
    int   cnt;

    vecs[0] = '{blk: ABC_BLK,   hin: IV_C,    exp: ABC_HASH};
    vecs[1] = '{blk: EMPTY_BLK, hin: IV_C,    exp: EMPTY_HASH};
    vecs[2] = '{blk: TWO_BLK1,  hin: IV_C,    exp: TWO_MID};
    vecs[3] = '{blk: TWO_BLK2,  hin: TWO_MID, exp: TWO_HASH};

    // Reset state, with begin asserted to show reset wins.
    begin_p = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {255'b0, busy_p}, 256'd0);
    check("reset complete", {255'b0, complete_p}, 256'd0);
    check("reset hash", hash_p, 256'd0);
    check("reset hold complete", {255'b0, complete_h}, 256'd0);
    begin_p = 1'b0;
    rst = 1'b0;

    // Known-answer vectors.
    for (int i = 0; i < 4; i++) begin
      start_job(1'b0, vecs[i].blk, vecs[i].hin);
      check($sformatf("vec%0d busy after accept", i), {255'b0, busy_p}, 256'd1);
      wait_done(1'b0, 0, lat);
      check($sformatf("vec%0d latency", i), lat, 256'd65);
      check($sformatf("vec%0d hash", i), hash_p, vecs[i].exp);
      check($sformatf("vec%0d busy at done", i), {255'b0, busy_p}, 256'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d complete pulse", i), {255'b0, complete_p}, 256'd0);
    end

    // begin_sha pulsed during round 10 with another block: ignored.
    start_job(1'b0, ABC_BLK, IV_C);
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk);
    block_in = EMPTY_BLK;
    begin_p  = 1'b1;
    @(posedge clk); #1;
    begin_p = 1'b0;
    wait_done(1'b0, 10, lat);
    check("ignored start latency", lat, 256'd65);
    check("ignored start hash", hash_p, ABC_HASH);
    count_completes(1'b0, 80, cnt);
    check("ignored start extra completes", cnt, 256'd0);
    check("ignored start busy", {255'b0, busy_p}, 256'd0);

    // Reset at round 30 aborts silently.
    start_job(1'b0, ABC_BLK, IV_C);
    repeat (30) begin @(posedge clk); #1; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid reset busy", {255'b0, busy_p}, 256'd0);
    check("mid reset hash", hash_p, 256'd0);
    count_completes(1'b0, 100, cnt);
    check("mid reset completes", cnt, 256'd0);
    start_job(1'b0, ABC_BLK, IV_C);
    wait_done(1'b0, 0, lat);
    check("post reset latency", lat, 256'd65);
    check("post reset hash", hash_p, ABC_HASH);

    // Hold mode: complete stays until the next accepted start.
    start_job(1'b1, ABC_BLK, IV_C);
    wait_done(1'b1, 0, lat);
    check("hold latency", lat, 256'd65);
    check("hold hash", hash_h, ABC_HASH);
    count_completes(1'b1, 20, cnt);
    check("hold complete held", cnt, 256'd20);
    start_job(1'b1, EMPTY_BLK, IV_C);
    check("hold complete cleared", {255'b0, complete_h}, 256'd0);
    check("hold busy restart", {255'b0, busy_h}, 256'd1);
    wait_done(1'b1, 0, lat);
    check("hold second hash", hash_h, EMPTY_HASH);

    // Pulse mode back-to-back: begin held high through the DONE cycle.
    @(negedge clk);
    block_in = ABC_BLK;
    hash_in  = IV_C;
    begin_p  = 1'b1;
    @(posedge clk); #1;
    block_in = EMPTY_BLK;
    wait_done(1'b0, 0, lat);
    check("b2b first latency", lat, 256'd65);
    check("b2b first hash", hash_p, ABC_HASH);
    @(posedge clk); #1;
    begin_p = 1'b0;
    check("b2b reaccept busy", {255'b0, busy_p}, 256'd1);
    check("b2b reaccept complete", {255'b0, complete_p}, 256'd0);
    wait_done(1'b0, 0, lat);
    check("b2b second latency", lat, 256'd65);
    check("b2b second hash", hash_p, EMPTY_HASH);

`ifdef SHA256_ABORT_EN
    // Abort at round 40: idle next edge, no complete, hash_out retained.
    start_job(1'b0, ABC_BLK, IV_C);
    repeat (40) begin @(posedge clk); #1; end
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort busy", {255'b0, busy_p}, 256'd0);
    count_completes(1'b0, 100, cnt);
    check("abort completes", cnt, 256'd0);
    check("abort hash retained", hash_p, EMPTY_HASH);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
